// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - modulo-N loadable up/down counter with enable, terminal-count pulse and load-range check (optional MODN_COUNTER_SATURATE_EN)
module modn_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             load_err
);

    // MODULUS is never materialised as a WIDTH-bit value (it would overflow
    // when MODULUS == 2**WIDTH); every decision compares against LAST instead.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    // Reject impossible configurations at elaboration time.
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "modn_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic             load_ok;
    logic             at_last;
    logic             at_zero;
    logic [WIDTH-1:0] count_up;
    logic [WIDTH-1:0] count_down;

    // Range check and neighbour values of the current count.
    always_comb begin
        load_ok    = (data <= LAST);
        at_last    = (data_out == LAST);
        at_zero    = (data_out == ZERO);
        count_up   = data_out + ONE;
        count_down = data_out - ONE;
    end

    // Count register with load > enable > hold priority; pulses default low each cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out <= ZERO;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                // A rejected load leaves the count alone and still suppresses counting.
                if (load_ok) begin
                    data_out <= data;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (mode) begin
`ifdef MODN_COUNTER_SATURATE_EN
                    // Parked at the upper bound: stay, no further pulse.
                    if (!at_last) begin
                        data_out <= count_up;
                        tc       <= (count_up == LAST);
                    end
`else
                    if (at_last) begin
                        data_out <= ZERO;
                        tc       <= 1'b1;
                    end else begin
                        data_out <= count_up;
                    end
`endif
                end else begin
`ifdef MODN_COUNTER_SATURATE_EN
                    // Parked at zero: stay, no further pulse.
                    if (!at_zero) begin
                        data_out <= count_down;
                        tc       <= (count_down == ZERO);
                    end
`else
                    if (at_zero) begin
                        data_out <= LAST;
                        tc       <= 1'b1;
                    end else begin
                        data_out <= count_down;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb/tb_modn_updown_counter.sv - self-checking bench for modn_updown_counter (MODULUS 15 and 16 instances)
module tb_modn_updown_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic       mode;
    logic [3:0] data;
    logic [3:0] q15;
    logic [3:0] q16;
    logic       tc15;
    logic       tc16;
    logic       err15;
    logic       err16;

    int tests;
    int fails;

    modn_updown_counter #(.WIDTH(4), .MODULUS(15)) dut (
        .clock(clk), .reset(reset), .en(en), .load(load), .mode(mode),
        .data(data), .data_out(q15), .tc(tc15), .load_err(err15)
    );

    modn_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clock(clk), .reset(reset), .en(en), .load(load), .mode(mode),
        .data(data), .data_out(q16), .tc(tc16), .load_err(err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       en;
        logic       md;
        logic [3:0] d;
        int         q;
        int         tc;
        int         err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock with the given inputs; returns with outputs settled #1 after the edge.
    task automatic cycle(input logic ld, input logic e, input logic md, input logic [3:0] d);
        load = ld;
        en   = e;
        mode = md;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        check("reset q15", int'(q15), 0);
        check("reset tc15", int'(tc15), 0);
        check("reset err15", int'(err15), 0);
        check("reset q16", int'(q16), 0);
        #1;
        reset = 1'b1;
    endtask

    // Reference behaviour from the rules: integer arithmetic, wrap or clamp at the range ends.
    function automatic void ref_step(input int m, input int cnt_in, input logic ld, input logic e,
                                     input logic md, input int d,
                                     output int cnt, output int tcv, output int errv);
        int nxt;
        cnt  = cnt_in;
        tcv  = 0;
        errv = 0;
        if (ld) begin
            if (d < m) cnt = d;
            else errv = 1;
        end else if (e) begin
            nxt = md ? cnt_in + 1 : cnt_in - 1;
`ifdef MODN_COUNTER_SATURATE_EN
            if (nxt >= 0 && nxt < m) begin
                cnt = nxt;
                tcv = (md && nxt == m - 1) || (!md && nxt == 0) ? 1 : 0;
            end
`else
            if (nxt == m) begin
                cnt = 0;
                tcv = 1;
            end else if (nxt < 0) begin
                cnt = m - 1;
                tcv = 1;
            end else begin
                cnt = nxt;
            end
`endif
        end
    endfunction

    initial begin
        int m15, m16, t15, t16, e15, e16;
        int n15, n16;
        logic rl, re, rm;
        logic [3:0] rd;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        mode  = 1'b0;
        data  = 4'd0;
        #1;

        // ---------------- vector table (MODULUS 15 instance) ----------------
`ifndef MODN_COUNTER_SATURATE_EN
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, (i + 1) % 15, (i == 14) ? 1 : 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd3, 3, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 2, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 1, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 14, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 13, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd7, 7, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd15, 7, 0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd9, 9, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 9, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 9, 0, 0});
`else
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd12, 12, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 13, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 14, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 14, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 14, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 14, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 13, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd1, 1, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 0, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd15, 1, 0, 1});
`endif

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].ld, vecs[i].en, vecs[i].md, vecs[i].d);
            check($sformatf("vec%0d q", i), int'(q15), vecs[i].q);
            check($sformatf("vec%0d tc", i), int'(tc15), vecs[i].tc);
            check($sformatf("vec%0d load_err", i), int'(err15), vecs[i].err);
        end

        // ---------------- MODULUS == 2**WIDTH: no overflow at 15 ----------------
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 4'd14);
        check("m16 load 14", int'(q16), 14);
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        check("m16 up to 15", int'(q16), 15);
`ifndef MODN_COUNTER_SATURATE_EN
        check("m16 tc at 15", int'(tc16), 0);
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        check("m16 wrap 0", int'(q16), 0);
        check("m16 wrap tc", int'(tc16), 1);
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        check("m16 after wrap", int'(q16), 1);
`else
        check("m16 tc at 15", int'(tc16), 1);
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        check("m16 parked 15", int'(q16), 15);
        check("m16 parked tc", int'(tc16), 0);
`endif
        check("m16 not X", int'($isunknown(q16)), 0);

        // ---------------- asynchronous reset mid-count ----------------
        cycle(1'b1, 1'b0, 1'b1, 4'd5);
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        check("pre-reset q", int'(q15), 6);
        #2;
        reset = 1'b0;
        #1;
        check("async reset q", int'(q15), 0);
        #2;
        reset = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        check("resume 1", int'(q15), 1);
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        check("resume 2", int'(q15), 2);

        // ---------------- reset clears a pending tc pulse ----------------
`ifndef MODN_COUNTER_SATURATE_EN
        cycle(1'b1, 1'b0, 1'b1, 4'd14);
`else
        cycle(1'b1, 1'b0, 1'b1, 4'd13);
`endif
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        check("pulse before reset", int'(tc15), 1);
        #1;
        reset = 1'b0;
        #1;
        check("pulse cleared tc", int'(tc15), 0);
        check("pulse cleared q", int'(q15), 0);
        #1;
        reset = 1'b1;

        // ---------------- randomized run against the reference model ----------------
        m15 = 0;
        m16 = 0;
        for (int i = 0; i < 400; i++) begin
            rl = ($urandom_range(0, 7) == 0);
            re = ($urandom_range(0, 3) != 0);
            rm = $urandom_range(0, 1) == 1;
            rd = 4'($urandom_range(0, 15));
            ref_step(15, m15, rl, re, rm, int'(rd), n15, t15, e15);
            ref_step(16, m16, rl, re, rm, int'(rd), n16, t16, e16);
            cycle(rl, re, rm, rd);
            m15 = n15;
            m16 = n16;
            check($sformatf("rnd%0d q15", i), int'(q15), m15);
            check($sformatf("rnd%0d tc15", i), int'(tc15), t15);
            check($sformatf("rnd%0d err15", i), int'(err15), e15);
            check($sformatf("rnd%0d q15 range", i), int'(q15 < 4'd15), 1);
            check($sformatf("rnd%0d q16", i), int'(q16), m16);
            check($sformatf("rnd%0d tc16", i), int'(tc16), t16);
            check($sformatf("rnd%0d err16", i), int'(err16), e16);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
- Parametrised successor to the team's mod-15 loadable up/down counter: modulo-N count, configurable width.
- Adds count-enable, a registered terminal-count pulse, load-range checking with an error pulse, and an optional saturating mode.
- Sits as a reusable leaf timer/sequence block. Its control pins match the existing counter bench interface (reset, mode, load, data, data_out), so the same driver and monitor structure extends to it.

Parameters:
- WIDTH, 4, bit width of data and data_out.
- MODULUS, 15, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH. Any other value is a fatal elaboration error.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clock.
- en  input  1  count enable; 0 holds the count (load still honoured).
- load  input  1  synchronous parallel load request.
- mode  input  1  direction: 1 = up, 0 = down.
- data  input  WIDTH  load value.
- data_out  output  WIDTH  current count, registered.
- tc  output  1  registered one-cycle pulse on a wrap (or a saturation hit, see Optional Feature).
- load_err  output  1  registered one-cycle pulse when a rejected load occurs.

Behaviour:
- Reset (reset=0, asynchronous): data_out=0, tc=0, load_err=0. Outputs stay there until the first posedge after reset=1.
- Priority each posedge: load > en > hold.
- Load, data < MODULUS: data_out <= data, tc <= 0, load_err <= 0. Load takes effect even when en=0.
- Load, data >= MODULUS: data_out unchanged, load_err <= 1 for one cycle, tc <= 0. A rejected load still blocks counting that cycle.
- Count, en=1, load=0, mode=1: data_out <= (data_out==MODULUS-1) ? 0 : data_out+1.
- Count, en=1, load=0, mode=0: data_out <= (data_out==0) ? MODULUS-1 : data_out-1.
- tc <= 1 on exactly the cycle data_out wraps: up MODULUS-1→0, down 0→MODULUS-1. Otherwise 0.
- Hold (en=0, load=0): data_out unchanged; tc=0, load_err=0.
- Latency: one cycle from sampled inputs to data_out, tc and load_err.
- Arithmetic is WIDTH-bit. It must not overflow when MODULUS == 2**WIDTH: compare against the terminal value, never compute MODULUS as WIDTH bits.
- mode changing mid-count takes effect on the next enabled edge; no pipeline bubble.
- Reset asserted mid-count: immediate return to 0; pending pulses cleared.
- data_out is never >= MODULUS in any reachable state.

Optional Feature:
- Macro: MODN_COUNTER_SATURATE_EN.
- Defined: counting saturates instead of wrapping.
  - Up at MODULUS-1 stays at MODULUS-1.
  - Down at 0 stays at 0.
  - tc pulses once, on the edge the count reaches the bound (e.g. 13→14 up). tc stays 0 while parked at the bound.
  - Load and load_err behaviour unchanged; load is the only way to leave a bound in the saturating direction.
  - Counting in the opposite direction leaves the bound normally.
- Undefined: wrap-around behaviour as above; no saturation logic synthesised.

Test Plan (WIDTH=4, MODULUS=15 unless stated):
- Reset then en=1, mode=1 for 16 cycles → data_out 1,2,…,14,0,1; tc=1 only on the cycle data_out becomes 0.
- Load data=3, then mode=0, en=1 for 5 cycles → 3,2,1,0,14,13; tc=1 on the 0→14 cycle.
- data_out=7, load=1 with data=15 → data_out stays 7, load_err=1 for one cycle, no count that cycle. Then load data=9 with en=0 → data_out=9, load_err=0.
- data_out=5, en=1, mode=1, reset pulled low mid-cycle → data_out=0 before the next posedge. Counting resumes 1,2… after release.
- WIDTH=4, MODULUS=16, up-count from 14 → 15,0,1; tc on the 15→0 cycle; data_out never X.
- With MODN_COUNTER_SATURATE_EN: load 12, up-count 5 cycles → 13,14,14,14,14, tc once on 13→14. Then mode=0 → 13. Down from 1 → 0,0; tc once.
